// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32 funct3
// codes, response error codes and bus transfer sizes.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) return (f3 > F3_W);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: return SIZE_H;
            F3_W:        return SIZE_W;
            default:     return SIZE_B;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
        case (f3_size(f3))
            SIZE_H:  return offset[0];
            SIZE_W:  return (offset != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobe/data replication and load lane extraction
// with sign or zero extension. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_ext
);

    logic [15:0] ld_shift;

    assign ld_shift = 16'(ld_data >> {offset, 3'b000});

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (funct3)
            F3_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << offset;
            end
            F3_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << offset;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_ext = '0;
        case (funct3)
            F3_B:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_H:    ld_ext = {{16{ld_shift[15]}}, ld_shift};
            F3_W:    ld_ext = ld_data;
            F3_BU:   ld_ext = {24'd0, ld_shift[7:0]};
            F3_HU:   ld_ext = {16'd0, ld_shift};
            default: ld_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_unit.sv
// Single-outstanding load/store unit driving the data-side read and write
// channels of the AXI bridge, with one writeback response per request.
module lsu_mem_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arsize,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            f3_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           rdata_q;
    logic [1:0]            err_q;

    logic        req_illegal, req_misalign;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [31:0] al_wdata, al_ext;
    logic [3:0]  al_wstrb;

    assign req_illegal  = f3_illegal(req_is_store, req_funct3);
    assign req_misalign = CHECK_ALIGN && misaligned(req_funct3, req_addr[1:0]);

    // One aligner serves both directions: the live request steers store lanes
    // in IDLE, the latched request steers load extraction afterwards.
    assign al_f3  = (state_q == S_IDLE) ? req_funct3    : f3_q;
    assign al_off = (state_q == S_IDLE) ? req_addr[1:0] : addr_q[1:0];

    lsu_lane_align u_align (
        .funct3   (al_f3),
        .offset   (al_off),
        .st_data  (req_wdata),
        .st_wdata (al_wdata),
        .st_wstrb (al_wstrb),
        .ld_data  (rdata),
        .ld_ext   (al_ext)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_illegal || req_misalign) state_d = S_RESP;
                    else if (req_is_store)           state_d = S_WR_REQ;
                    else                             state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) state_d = S_RESP;
            end
            S_WR_REQ: begin
                // Address and data are accepted as a pair by the bridge.
                awvalid = 1'b1;
                wvalid  = 1'b1;
                if (awready && wready) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    addr_q  <= req_addr;
                    f3_q    <= req_funct3;
                    wdata_q <= al_wdata;
                    wstrb_q <= req_is_store ? al_wstrb : 4'b0000;
                    rdata_q <= '0;
                    err_q   <= req_illegal  ? ERR_ILLEGAL  :
                               req_misalign ? ERR_MISALIGN : ERR_OK;
                end
                S_RD_DATA: if (rvalid) begin
                    rdata_q <= al_ext;
                    err_q   <= (rresp != 2'b00) ? ERR_BUS : ERR_OK;
                end
                S_WR_RESP: if (bvalid) begin
                    err_q <= (bresp != 2'b00) ? ERR_BUS : ERR_OK;
                end
                default: ;
            endcase
        end
    end

    assign araddr     = addr_q;
    assign arsize     = f3_size(f3_q);
    assign awaddr     = addr_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Randomized bench for lsu_mem_unit: a slave model with programmable stalls
// plus a behavioural reference model for lanes, errors and latency.
module tb_lsu_mem_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        arvalid, arready = 1'b0;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        rvalid = 1'b0, rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        awvalid, awready = 1'b0;
    logic [31:0] awaddr;
    logic        wvalid, wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0, bready;
    logic [1:0]  bresp = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    lsu_mem_unit #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Reference model, written from the ISA-level rules.
    function automatic logic [1:0] ref_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (st && f3 > 2) return 2'b11;
        if (!st && (f3 == 3 || f3 == 6 || f3 == 7)) return 2'b11;
        sz = (f3 == 2) ? 4 : (f3 == 1 || f3 == 5) ? 2 : 1;
        if ((a % sz) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [2:0] ref_size(input logic [2:0] f3);
        return (f3 == 2) ? 3'd2 : (f3 == 1 || f3 == 5) ? 3'd1 : 3'd0;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        int base;
        base = (f3 == 0) ? 1 : (f3 == 1) ? 3 : 15;
        if (f3 == 2) return 4'hF;
        return 4'((base << (a % 4)) & 15);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] sh, b, h;
        sh = rd >> (8 * (a % 4));
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return rd;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    // One full request/response with the slave stalling each channel as told.
    task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input logic [1:0] rr, input logic [1:0] br,
                          input int ar_l, input int r_l, input int aw_l,
                          input int w_l, input int b_l, input int rsp_l);
        logic [1:0]  e;
        logic [31:0] exp_d;
        int          n;
        bit          zero;
        e     = ref_err(st, f3, a);
        exp_d = 32'd0;
        zero  = (ar_l == 0 && r_l == 0 && aw_l == 0 && w_l == 0 && b_l == 0);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        cyc = 0;
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        if (e != 2'b00) begin
            check("err_early_resp", resp_valid, 1);
            check("err_no_bus", {arvalid, awvalid, wvalid}, 0);
        end else if (!st) begin
            n = 0;
            while (!arvalid && n < 16) begin step(); n++; end
            if (!arvalid) begin check("ar_timeout", 0, 1); return; end
            check("araddr", araddr, a);
            check("arsize", arsize, ref_size(f3));
            check("ar_no_aw", awvalid, 0);
            repeat (ar_l) begin step(); check("ar_hold", {arvalid, araddr}, {1'b1, a}); end
            arready = 1'b1; step(); arready = 1'b0;
            check("ar_drop", arvalid, 0);
            repeat (r_l) step();
            check("rready", rready, 1);
            rvalid = 1'b1; rdata = rd; rresp = rr;
            step();
            rvalid = 1'b0; rdata = $urandom;
            exp_d = ref_load(f3, a, rd);
            e = (rr != 2'b00) ? 2'b10 : 2'b00;
        end else begin
            n = 0;
            while (!awvalid && n < 16) begin step(); n++; end
            if (!awvalid) begin check("aw_timeout", 0, 1); return; end
            check("w_with_aw", wvalid, 1);
            check("ar_not_with_w", arvalid, 0);
            check("awaddr", awaddr, a);
            check("wdata", wdata, ref_wdata(f3, wd));
            check("wstrb", wstrb, ref_strb(f3, a));
            for (int k = 0; k < 16; k++) begin
                awready = (k >= aw_l);
                wready  = (k >= w_l);
                if (awready && wready) break;
                step();
                check("aw_w_hold", {awvalid, wvalid}, 2'b11);
            end
            step(); awready = 1'b0; wready = 1'b0;
            check("aw_w_drop", {awvalid, wvalid}, 2'b00);
            repeat (b_l) step();
            check("bready", bready, 1);
            bvalid = 1'b1; bresp = br;
            step();
            bvalid = 1'b0;
            e = (br != 2'b00) ? 2'b10 : 2'b00;
        end
        n = 0;
        while (!resp_valid && n < 16) begin step(); n++; end
        if (!resp_valid) begin check("resp_timeout", 0, 1); return; end
        if (ref_err(st, f3, a) != 2'b00) check("latency_err", cyc, 1);
        else if (zero)                   check("latency", cyc, 3);
        check("resp_rdata", resp_rdata, exp_d);
        check("resp_err", resp_err, e);
        repeat (rsp_l) begin
            step();
            check("resp_hold", {resp_valid, req_ready, resp_err}, {1'b1, 1'b0, e});
            check("resp_hold_data", resp_rdata, exp_d);
        end
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
        check("resp_drop", resp_valid, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    initial begin
        repeat (3) step();
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {resp_valid, arvalid, rready, awvalid, wvalid, bready}, 0);
        check("rst_resp", {resp_err, resp_rdata[29:0]}, 0);
        check("rst_regs", araddr | wdata | 32'(wstrb), 0);
        reset = 1'b0;
        step();

        // Directed cases.
        do_txn(0, 3'd0, 32'h8000_0003, 0, 32'h80FF_1234, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        do_txn(1, 3'd1, 32'h8000_0102, 32'h0000_BEEF, 0, 2'b00, 2'b00, 0, 0, 0, 3, 1, 1);
        do_txn(0, 3'd2, 32'h8000_0006, 0, 32'h1111_1111, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2);
        do_txn(0, 3'd5, 32'h0200_004A, 0, 32'hABCD_0000, 2'b10, 2'b00, 1, 2, 0, 0, 0, 0);
        do_txn(0, 3'd3, 32'h8000_0000, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        do_txn(1, 3'd2, 32'h8000_0000, 32'hDEAD_BEEF, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        do_txn(1, 3'd0, 32'h8000_0011, 32'h0000_00A5, 0, 2'b00, 2'b11, 0, 0, 2, 0, 0, 0);

        // Reset while waiting for read data.
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h8000_0004;
        step(); req_valid = 1'b0;
        arready = 1'b1; step(); arready = 1'b0;
        check("pre_rst_rready", rready, 1);
        reset = 1'b1; step(); reset = 1'b0;
        check("midrst_valids", {resp_valid, arvalid, rready, awvalid, wvalid, bready}, 0);
        check("midrst_req_ready", req_ready, 1);
        do_txn(0, 3'd4, 32'h8000_0001, 0, 32'h0000_9900, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            bit          st;
            logic [2:0]  f3;
            bit          fast;
            st   = 1'($urandom);
            f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
                   st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            fast = ($urandom_range(0, 3) == 0);
            do_txn(st, f3, $urandom, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                   ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                   fast ? 0 : $urandom_range(0, 3), fast ? 0 : $urandom_range(0, 3),
                   fast ? 0 : $urandom_range(0, 3), fast ? 0 : $urandom_range(0, 3),
                   fast ? 0 : $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Load/store unit sitting directly upstream of the core's AXI bridge.
- Accepts one memory request at a time from the execute stage and drives the bridge's data-side channels:
  - read: exu_ar* / lsu_r*
  - write: exu_aw* / exu_w* / lsu_b*
- Performs byte-lane alignment, write strobe generation and load sign/zero extension, and returns one response per request to writeback.

Parameters:
- ADDR_WIDTH, 32, width of request and bus addresses.
- CHECK_ALIGN, 1, 1 = misaligned half/word accesses are rejected without a bus transaction; 0 = issued to bus unchecked.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  execute-stage request valid
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data (unshifted, in low bits)
- resp_valid  out  1  response valid
- resp_ready  in  1  writeback accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 bus error, 11 illegal funct3
- arvalid / arready  out / in  1 / 1  read address handshake
- araddr  out  ADDR_WIDTH  read address (unaligned byte address)
- arsize  out  3  0 = byte, 1 = half, 2 = word
- rvalid / rready  in / out  1 / 1  read data handshake
- rdata  in  32  read data on natural byte lanes
- rresp  in  2  read response
- awvalid / awready  out / in  1 / 1  write address handshake
- awaddr  out  ADDR_WIDTH  write address
- wvalid / wready  out / in  1 / 1  write data handshake
- wdata  out  32  lane-shifted store data
- wstrb  out  4  byte strobes
- bvalid / bready  in / out  1 / 1  write response handshake
- bresp  in  2  write response

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP. Reset → IDLE.
- Reset values: all valid/ready outputs 0 except req_ready = 1; resp_rdata = 0; resp_err = 0; address/data/strobe registers 0.
- req_ready = (state == IDLE). On req_valid && req_ready, latch addr, funct3, is_store and shifted wdata/strobe. The next state is chosen as follows:
  - illegal funct3: load funct3 in {3, 6, 7}, or store funct3 > 2 → RESP, err 11.
  - CHECK_ALIGN = 1 and misaligned → RESP, err 01. Misaligned means half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - otherwise load → RD_ADDR; store → WR_REQ.
- RD_ADDR:
  - arvalid = 1; araddr and arsize held stable.
  - arready → RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, capture the extracted and extended lane data and go to RESP.
  - err = 10 if rresp ≠ 00; data is still captured.
- WR_REQ:
  - awvalid = wvalid = 1 asserted together, held until both awready and wready are high in the same cycle; then → WR_RESP.
  - The bridge captures both channels simultaneously; a handshake of only one channel is never counted.
- WR_RESP:
  - bready = 1.
  - bvalid → RESP; err = 10 if bresp ≠ 00.
- RESP:
  - resp_valid = 1, outputs held stable until resp_ready; then → IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Store lane rules, with s = addr[1:0] used as the byte offset:
  - SB: wstrb = 0001 << s, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << s, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata unchanged.
- Load lane rules:
  - byte = rdata >> (8 * addr[1:0]), low 8 bits.
  - half = low 16 bits of that shift.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Minimum latency:
  - load accepted at cycle 0: arvalid at cycle 1; with arready at 1 and rvalid at 2, resp_valid at cycle 3.
  - error response: resp_valid at cycle 1.
- Valid outputs never depend combinationally on any ready input.
- Reset mid-transaction: immediate return to IDLE, all channel valids drop. The bridge shares the same reset, so no orphan transaction persists.
- Only one outstanding transaction exists at any time; read and write are never concurrent.

Decomposition:
- Shared package lsu_pkg holds:
  - state encoding
  - funct3 constants F3_B = 0, F3_H = 1, F3_W = 2, F3_BU = 4, F3_HU = 5
  - error codes ERR_OK / ERR_MISALIGN / ERR_BUS / ERR_ILLEGAL
  - arsize constants
- Sub-module lsu_lane_align is purely combinational and implements store strobe/data replication and load extraction/extension; it is unit-testable on its own.

Test Plan:
- LB from 0x80000003, rdata = 0x80FF_1234, rresp = 00 → arsize = 0, araddr = 0x80000003, resp_rdata = 0xFFFFFF80, err 00, resp_valid at cycle 3 with zero-wait slave.
- SH to 0x80000102, wdata = 0x0000_BEEF → wdata = 0xBEEF_BEEF, wstrb = 1100, awvalid and wvalid rise together; awready high, wready delayed 3 cycles → no advance until both ready.
- LW from 0x80000006 with CHECK_ALIGN = 1 → no arvalid ever, resp_valid at cycle 1, err 01, rdata 0.
- LHU from 0x0200004A, rdata = 0xABCD_0000, rresp = 10 → resp_rdata = 0x0000ABCD, err 10.
- Load funct3 = 3 → err 11, no bus activity; then back-to-back SW 0x80000000 / 0xDEADBEEF → wstrb 1111, bresp 00, err 00.
- Assert reset while in RD_DATA with resp_ready low → next cycle all valids 0, req_ready 1; a subsequent LBU from 0x80000001 with rdata 0x0000_9900 completes with resp_rdata 0x00000099.
